// File: rtl/trigger_sequencer.sv
// Multi-stage mask/type/level trigger engine with per-stage occurrence counts,
// pre-trigger holdoff and trigger sample index reporting.
module trigger_sequencer #(
    parameter  int size    = 32,
    parameter  int levels  = 8,
    parameter  int cnt_w   = 16,
    parameter  int saddr_w = 24,
    localparam int lvl_w   = $clog2(levels + 1),
    localparam int stg_w   = (levels > 1) ? $clog2(levels) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [size-1:0]           sample,
    input  logic                      sample_valid,
    input  logic                      arm,
    input  logic                      abort,
    input  logic [lvl_w-1:0]          num_levels,
    input  logic [saddr_w-1:0]        pretrig_min,
    input  logic [levels*size-1:0]    trig_mask,
    input  logic [levels*size-1:0]    trig_type,
    input  logic [levels*size-1:0]    trig_level,
    input  logic [levels*cnt_w-1:0]   trig_count,
    output logic                      armed,
    output logic                      triggered,
    output logic                      trig_pulse,
    output logic [stg_w-1:0]          stage,
    output logic [saddr_w-1:0]        trigger_pos
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLDOFF,
        S_RUN,
        S_TRIGGERED
    } state_t;

    state_t             state_q;
    logic               armed_q;
    logic               triggered_q;
    logic               trig_pulse_q;
    logic [stg_w-1:0]   stage_q;
    logic [cnt_w-1:0]   cnt_q;
    logic [saddr_w-1:0] idx_q;
    logic [saddr_w-1:0] trigger_pos_q;
    logic [size-1:0]    prev_q;
    logic               prev_valid_q;

    logic [size-1:0]  mask_arr  [levels];
    logic [size-1:0]  type_arr  [levels];
    logic [size-1:0]  level_arr [levels];
    logic [cnt_w-1:0] count_arr [levels];

    for (genvar gi = 0; gi < levels; gi++) begin : g_unpack
        assign mask_arr[gi]  = trig_mask[gi*size +: size];
        assign type_arr[gi]  = trig_type[gi*size +: size];
        assign level_arr[gi] = trig_level[gi*size +: size];
        // A programmed count of zero behaves like one.
        assign count_arr[gi] = (trig_count[gi*cnt_w +: cnt_w] == '0)
                             ? cnt_w'(1) : trig_count[gi*cnt_w +: cnt_w];
    end

    logic [size-1:0]    cur_mask, cur_type, cur_level;
    logic [size-1:0]    bit_ok;
    logic               stage_match;
    logic [lvl_w-1:0]   nl_eff;
    logic               last_stage;
    logic               count_done;
    logic               fire;
    logic [saddr_w-1:0] idx_inc;

    assign cur_mask  = mask_arr[stage_q];
    assign cur_type  = type_arr[stage_q];
    assign cur_level = level_arr[stage_q];

    // Edge bits additionally need a previous sample that differs from this one.
    assign bit_ok = ~cur_mask
                  | (~(sample ^ cur_level)
                     & (~cur_type | ({size{prev_valid_q}} & (prev_q ^ sample))));
    assign stage_match = &bit_ok;

    assign nl_eff     = (num_levels > lvl_w'(levels)) ? lvl_w'(levels) : num_levels;
    assign last_stage = (lvl_w'(stage_q) == nl_eff - lvl_w'(1));
    assign count_done = (cnt_q == count_arr[stage_q] - cnt_w'(1));
    assign fire       = (nl_eff == '0) || (stage_match && count_done && last_stage);
    assign idx_inc    = (&idx_q) ? idx_q : idx_q + saddr_w'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            armed_q       <= 1'b0;
            triggered_q   <= 1'b0;
            trig_pulse_q  <= 1'b0;
            stage_q       <= '0;
            cnt_q         <= '0;
            idx_q         <= '0;
            trigger_pos_q <= '0;
            prev_q        <= '0;
            prev_valid_q  <= 1'b0;
        end else begin
            trig_pulse_q <= 1'b0;
            if (abort) begin
                state_q       <= S_IDLE;
                armed_q       <= 1'b0;
                triggered_q   <= 1'b0;
                stage_q       <= '0;
                cnt_q         <= '0;
                trigger_pos_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE, S_TRIGGERED: begin
                        if (arm) begin
                            state_q       <= S_HOLDOFF;
                            armed_q       <= 1'b1;
                            triggered_q   <= 1'b0;
                            stage_q       <= '0;
                            cnt_q         <= '0;
                            idx_q         <= '0;
                            trigger_pos_q <= '0;
                            prev_valid_q  <= 1'b0;
                        end
                    end
                    S_HOLDOFF: begin
                        if (sample_valid) begin
                            idx_q        <= idx_inc;
                            prev_q       <= sample;
                            prev_valid_q <= 1'b1;
                        end
                        if ((pretrig_min == '0) || (sample_valid && (idx_inc == pretrig_min))) begin
                            state_q <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (sample_valid) begin
                            idx_q        <= idx_inc;
                            prev_q       <= sample;
                            prev_valid_q <= 1'b1;
                            if (fire) begin
                                state_q       <= S_TRIGGERED;
                                armed_q       <= 1'b0;
                                triggered_q   <= 1'b1;
                                trig_pulse_q  <= 1'b1;
                                trigger_pos_q <= idx_q;
                                cnt_q         <= '0;
                            end else if (stage_match) begin
                                if (count_done) begin
                                    cnt_q   <= '0;
                                    stage_q <= stage_q + stg_w'(1);
                                end else begin
                                    cnt_q <= cnt_q + cnt_w'(1);
                                end
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign armed       = armed_q;
    assign triggered   = triggered_q;
    assign trig_pulse  = trig_pulse_q;
    assign stage       = stage_q;
    assign trigger_pos = trigger_pos_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer: single/edge/multi-stage triggers,
// holdoff, stage clamping, abort and asynchronous reset.
module tb_trigger_sequencer;

    localparam int SIZE    = 32;
    localparam int LEVELS  = 8;
    localparam int CNT_W   = 16;
    localparam int SADDR_W = 24;
    localparam int LVL_W   = $clog2(LEVELS + 1);
    localparam int STG_W   = $clog2(LEVELS);

    logic                     clk;
    logic                     reset;
    logic [SIZE-1:0]          sample;
    logic                     sample_valid;
    logic                     arm;
    logic                     abort;
    logic [LVL_W-1:0]         num_levels;
    logic [SADDR_W-1:0]       pretrig_min;
    logic [LEVELS*SIZE-1:0]   trig_mask;
    logic [LEVELS*SIZE-1:0]   trig_type;
    logic [LEVELS*SIZE-1:0]   trig_level;
    logic [LEVELS*CNT_W-1:0]  trig_count;
    logic                     armed;
    logic                     triggered;
    logic                     trig_pulse;
    logic [STG_W-1:0]         stage;
    logic [SADDR_W-1:0]       trigger_pos;

    int n_checks = 0;
    int n_pass   = 0;

    trigger_sequencer #(
        .size(SIZE), .levels(LEVELS), .cnt_w(CNT_W), .saddr_w(SADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .sample(sample), .sample_valid(sample_valid),
        .arm(arm), .abort(abort), .num_levels(num_levels), .pretrig_min(pretrig_min),
        .trig_mask(trig_mask), .trig_type(trig_type), .trig_level(trig_level),
        .trig_count(trig_count), .armed(armed), .triggered(triggered),
        .trig_pulse(trig_pulse), .stage(stage), .trigger_pos(trigger_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-18s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp(input logic [31:0] v);
        sample       = v;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic clr_cfg();
        trig_mask   = '0;
        trig_type   = '0;
        trig_level  = '0;
        trig_count  = '0;
        pretrig_min = '0;
        num_levels  = '0;
    endtask

    task automatic set_stage(input int i, input logic [31:0] m, input logic [31:0] t,
                             input logic [31:0] l, input logic [15:0] c);
        trig_mask[i*SIZE +: SIZE]    = m;
        trig_type[i*SIZE +: SIZE]    = t;
        trig_level[i*SIZE +: SIZE]   = l;
        trig_count[i*CNT_W +: CNT_W] = c;
    endtask

    initial begin
        reset = 1'b1; sample = '0; sample_valid = 1'b0; arm = 1'b0; abort = 1'b0;
        clr_cfg();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_armed", 32'(armed), 0);
        chk("rst_triggered", 32'(triggered), 0);
        chk("rst_pulse", 32'(trig_pulse), 0);
        chk("rst_stage", 32'(stage), 0);
        chk("rst_trigpos", 32'(trigger_pos), 0);
        reset = 1'b0;
        tick();

        // Single level stage on bit 0.
        num_levels = 1;
        set_stage(0, 32'h1, 32'h0, 32'h1, 16'd1);
        do_arm();
        chk("t1_armed_hold", 32'(armed), 1);
        tick();
        chk("t1_armed_run", 32'(armed), 1);
        smp(32'h0);
        chk("t1_s0_trig", 32'(triggered), 0);
        smp(32'h0);
        chk("t1_s1_trig", 32'(triggered), 0);
        smp(32'h1);
        chk("t1_trig", 32'(triggered), 1);
        chk("t1_pulse", 32'(trig_pulse), 1);
        chk("t1_pos", 32'(trigger_pos), 2);
        chk("t1_armed_off", 32'(armed), 0);
        tick();
        chk("t1_pulse_once", 32'(trig_pulse), 0);
        chk("t1_trig_hold", 32'(triggered), 1);
        do_abort();
        chk("t1_abort_trig", 32'(triggered), 0);
        chk("t1_abort_pos", 32'(trigger_pos), 0);

        // Rising edge on bit 7; first sample has no predecessor.
        clr_cfg();
        num_levels = 1;
        set_stage(0, 32'h80, 32'h80, 32'h80, 16'd1);
        do_arm();
        tick();
        smp(32'h80);
        chk("t2_first_noedge", 32'(triggered), 0);
        smp(32'h00);
        chk("t2_fall_nomatch", 32'(triggered), 0);
        smp(32'h80);
        chk("t2_rise_trig", 32'(triggered), 1);
        chk("t2_pos", 32'(trigger_pos), 2);
        do_abort();

        // Two stages: bit0 x3 (non-consecutive), then bit1 with count 0.
        clr_cfg();
        num_levels = 2;
        set_stage(0, 32'h1, 32'h0, 32'h1, 16'd3);
        set_stage(1, 32'h2, 32'h0, 32'h2, 16'd0);
        do_arm();
        tick();
        smp(32'h1);
        smp(32'h0);
        sample = 32'h1; sample_valid = 1'b0;
        tick();
        smp(32'h1);
        chk("t3_stage_3rd", 32'(stage), 0);
        smp(32'h1);
        chk("t3_stage_4th", 32'(stage), 1);
        chk("t3_not_yet", 32'(triggered), 0);
        smp(32'h2);
        chk("t3_trig", 32'(triggered), 1);
        chk("t3_pos", 32'(trigger_pos), 4);
        do_abort();

        // Abort while in stage 1, then re-arm restarts the index.
        do_arm();
        tick();
        smp(32'h1); smp(32'h1); smp(32'h1);
        chk("t4_stage1", 32'(stage), 1);
        do_abort();
        chk("t4_abort_armed", 32'(armed), 0);
        chk("t4_abort_stage", 32'(stage), 0);
        do_arm();
        tick();
        smp(32'h1); smp(32'h1); smp(32'h1); smp(32'h2);
        chk("t4_rearm_trig", 32'(triggered), 1);
        chk("t4_rearm_pos", 32'(trigger_pos), 3);
        do_abort();

        // Holdoff of 5 valid samples with an always-matching stage.
        clr_cfg();
        num_levels  = 1;
        pretrig_min = 5;
        do_arm();
        for (int i = 0; i < 5; i++) begin
            smp(32'(i));
            chk("t5_holdoff", 32'(triggered), 0);
        end
        smp(32'h5);
        chk("t5_trig", 32'(triggered), 1);
        chk("t5_pos", 32'(trigger_pos), 5);
        do_abort();

        // num_levels above the implemented count clamps to 8 stages.
        clr_cfg();
        num_levels = 15;
        do_arm();
        tick();
        for (int i = 0; i < 7; i++) smp(32'(i));
        chk("t6_clamp_stage", 32'(stage), 7);
        chk("t6_clamp_notrig", 32'(triggered), 0);
        smp(32'h7);
        chk("t6_clamp_trig", 32'(triggered), 1);
        chk("t6_clamp_pos", 32'(trigger_pos), 7);
        do_abort();

        // Zero active stages: first valid sample in RUN triggers.
        clr_cfg();
        set_stage(0, 32'hFFFF_FFFF, 32'h0, 32'h0, 16'd1);
        do_arm();
        tick();
        smp(32'h1234_5678);
        chk("t7_nl0_trig", 32'(triggered), 1);
        chk("t7_nl0_pos", 32'(trigger_pos), 0);
        do_abort();

        // Asynchronous reset between edges while in RUN.
        clr_cfg();
        num_levels = 2;
        set_stage(0, 32'h1, 32'h0, 32'h1, 16'd3);
        set_stage(1, 32'h2, 32'h0, 32'h2, 16'd1);
        do_arm();
        tick();
        smp(32'h1); smp(32'h1); smp(32'h1);
        chk("t8_pre_stage", 32'(stage), 1);
        #2 reset = 1'b1;
        #1;
        chk("t8_async_armed", 32'(armed), 0);
        chk("t8_async_stage", 32'(stage), 0);
        #1 reset = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("t8_rearm_armed", 32'(armed), 1);
        do_abort();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/trigger_sequencer.md
# trigger_sequencer

Parametrised multi-stage trigger engine for the logic capture path. It evaluates a configurable number of mask/type/level stages against the sample stream, in order. It adds per-stage occurrence counts and a pre-trigger holdoff. It reports the index of the triggering sample so the capture controller can place the trigger in its circular buffer, and it sits between the sampler and the capture/FIFO logic in the sample clock domain.

## Interface
- `size`, 32, sample width in bits
- `levels`, 8, number of stages implemented (≥1)
- `cnt_w`, 16, width of each per-stage occurrence count
- `saddr_w`, 24, width of sample index / holdoff values
- `lvl_w`, derived `$clog2(levels+1)`; `stg_w`, derived `max(1,$clog2(levels))`

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `sample`  in  size  input sample data
- `sample_valid`  in  1  `sample` is a new sample this cycle
- `arm`  in  1  start a trigger search (level-sampled)
- `abort`  in  1  cancel; priority over `arm`
- `num_levels`  in  lvl_w  active stage count; values > `levels` clamp to `levels`
- `pretrig_min`  in  saddr_w  valid samples to accept before matching is enabled
- `trig_mask`  in  levels*size  stage i at bits [i*size +: size]; 1 = bit participates
- `trig_type`  in  levels*size  per bit: 0 = level, 1 = edge
- `trig_level`  in  levels*size  per bit: required level, or edge direction (1 = rising, 0 = falling)
- `trig_count`  in  levels*cnt_w  matches required per stage; 0 is treated as 1
- `armed`  out  1  high in HOLDOFF or RUN
- `triggered`  out  1  high in TRIGGERED
- `trig_pulse`  out  1  one-cycle pulse on entry to TRIGGERED
- `stage`  out  stg_w  current stage index
- `trigger_pos`  out  saddr_w  0-based index, counted from arm, of the triggering sample

## Operation
- States: IDLE, HOLDOFF, RUN, TRIGGERED.
- IDLE, `arm`=1 → HOLDOFF. Arming clears sample index, stage, occurrence counter and the previous-sample-valid flag.
- HOLDOFF: each valid sample increments the index. The state moves to RUN on the edge where the index reaches `pretrig_min`; with `pretrig_min`=0 it moves to RUN on the next edge regardless of `sample_valid`. Samples in HOLDOFF are never matched, but they do update the previous-sample register.
- RUN, per valid sample, for stage `stage`:
  - A bit with mask=1 and type=0 matches when `sample[b]==level[b]`.
  - A bit with mask=1 and type=1 matches when `prev[b]!=sample[b]` and `sample[b]==level[b]`. It never matches while no previous sample exists.
  - The stage matches when all masked bits match. Mask all-zero matches every valid sample.
- On a stage match the occurrence counter increments. Matches need not be consecutive.
- When the counter reaches the effective count, the counter clears and `stage` increments. On the last active stage the block enters TRIGGERED instead, `trigger_pos` latches that sample's index and `trig_pulse` fires.
- `num_levels`=0: the first valid sample in RUN triggers.
- TRIGGERED holds until `abort` → IDLE, or `arm` → HOLDOFF (re-arm, full clear).
- `abort`=1 in any state → IDLE next edge; `stage`, counter and `trigger_pos` clear.
- `arm` while in HOLDOFF/RUN is ignored.
- Sample index saturates at all-ones; it does not wrap.
- Configuration inputs must be static while `armed`; changing them mid-run is undefined.

## Timing
- Reset values: `armed`=0, `triggered`=0, `trig_pulse`=0, `stage`=0, `trigger_pos`=0, state IDLE.
- All outputs are registered. A sample presented with `sample_valid` at edge N affects outputs visible after edge N (1-cycle latency).
- `armed` rises one edge after `arm` is sampled in IDLE.
- A stage advance takes effect at the same edge as the completing match. The next valid sample is therefore compared against the new stage, with no dead cycle.
- `sample_valid`=0 cycles: no evaluation, no index increment, and `prev` is held.
- `reset` asserted mid-operation returns all state to reset values immediately (asynchronously).

## Test plan
- `num_levels`=1, mask=0x1, type=0, level=1, count=1, `pretrig_min`=0. Arm, then samples 0,0,1 → `triggered` after 3rd sample, `trigger_pos`=2, one `trig_pulse`.
- Edge stage: mask=0x80, type=0x80, level=0x80. First sample after arm =0x80 → no trigger. Samples 0x00, 0x80 → trigger on the rising edge, `trigger_pos`=2.
- Two stages: stage0 level `sample[0]`=1 with count=3, stage1 `sample[1]`=1. Stream 1,0,1,1,2 → `stage` goes 0→1 after 4th sample, trigger at index 4.
- `pretrig_min`=5 with an always-matching stage → no trigger before index 5; trigger at index 5 (6th valid sample).
- Abort while `stage`=1 → next edge `armed`=0, `stage`=0. A later arm restarts the index from 0.
- Async reset asserted mid-RUN between clock edges → outputs 0 immediately. `arm` sampled at the first edge after release → `armed`=1.
